rsc_stream_encoder: RTL
=======================

# rsc_stream_encoder

LTE turbo constituent (RSC) encoder that produces the soft-symbol stream consumed by the SISO decoder `top`. It accepts one information bit per handshake and emits BPSK-mapped 16-bit signed symbols in interleaved systematic/parity order. Each block ends with the 3-step trellis termination, 6 symbols. The block drives `top.in`/`valid_in` directly in loopback benches and hardware self-test.

## Interface
- `AMP`, 1024 — symbol magnitude; bit 0 maps to +AMP, bit 1 maps to −AMP; legal range 1..32767.
- `MIN_BLK`, 40 — smallest legal block length.
- `MAX_BLK`, 6144 — largest legal block length.

- `clk`  in  1  — clock; all logic on the rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `blklen`  in  16  — block length K in bits.
- `valid_blklen`  in  1  — single-cycle strobe; samples `blklen`.
- `in_bit`  in  1  — information bit.
- `valid_in`  in  1  — `in_bit` is valid.
- `ready`  out  1  — encoder accepts `in_bit` this cycle.
- `out`  out  16  — signed soft symbol.
- `valid_out`  out  1  — `out` is valid.
- `last_out`  out  1  — marks the final tail symbol of the block.
- `err_blklen`  out  1  — one-cycle pulse when a `blklen` outside MIN_BLK..MAX_BLK is strobed.

## Operation
- **Encoder polynomials:** feedback g0 = 1+D²+D³, feedforward g1 = 1+D+D³; state registers s1, s2, s3.
- **Data step:** a = u ^ s2 ^ s3; parity z = a ^ s1 ^ s3; next state {s1,s2,s3} ← {a,s1,s2}.
- **Tail step:** u = s2 ^ s3, which forces a = 0; x = u; z = s1 ^ s3; state shifts as in the data step. Three tail steps return the trellis to state 0.
- **Symbol mapping:** symbol = bit ? −AMP : +AMP, in two's complement.
- **FSM IDLE:**
  - Waits for `valid_blklen`.
  - Legal length: latch K, clear the bit counter and state, go to DATA.
  - Illegal length: pulse `err_blklen`, stay in IDLE.
- **FSM DATA:**
  - A 1-bit phase toggles between SYS and PAR.
  - `ready` = 1 only in phase SYS.
  - A handshake (`ready` && `valid_in`) emits the systematic symbol, then the parity symbol on the next cycle.
  - When the counter reaches K after a PAR cycle, go to TAIL.
- **FSM TAIL:** 6 cycles emitting x_K, z_K, x_K+1, z_K+1, x_K+2, z_K+2, then return to IDLE.
- **Block size:** every block emits exactly 2K+6 symbols.
- **`valid_blklen` outside IDLE:** ignored; no error pulse.
- **`valid_in` while `ready`=0:** ignored; the bit is not consumed.
- **Counter width:** 13 bits, enough for MAX_BLK.

## Timing
- **Reset values:** `out`=0, `valid_out`=0, `last_out`=0, `ready`=0, `err_blklen`=0; FSM=IDLE, state=000, counter=0.
- **Entering DATA:** `valid_blklen` sampled at edge E; `ready`=1 from the cycle after E.
- **Per-bit timing:**
  - Handshake sampled at edge T: sys symbol registered on `out` after edge T, with `valid_out`=1.
  - Parity symbol appears after edge T+1.
  - `ready`=0 during the cycle after T.
  - `ready` returns to 1 after edge T+1 if bits remain.
  - Maximum throughput is one bit per 2 cycles. Stalls on `valid_in` insert gaps with `valid_out`=0.
- **Block end:** last bit handshaken at T:
  - Tail symbols appear after edges T+2..T+7, back-to-back.
  - `last_out`=1 with the T+7 symbol only.
  - `ready`=0 throughout the tail.
- **Next block:** earliest next `valid_blklen` is accepted in the cycle after the last symbol (IDLE).
- **`err_blklen`:** asserted in the cycle after the illegal strobe, for one cycle.
- **Reset mid-block:** all outputs return to reset values immediately; the partial block is discarded; no `last_out`.

## Test plan
- **All zeros:** K=40, 40 zeros at full rate → 86 symbols, all +1024; symbols arrive every cycle; `last_out` only on symbol 86; `ready` toggles 1/0.
- **Single one:** K=40, bit0=1 then zeros → symbol pairs (sys,par): (−1024,−1024), (+1024,−1024), (+1024,−1024), (+1024,−1024); whole stream matches the golden model, including tail returning state to 000.
- **Random blocks:** random K ∈ {40, 512, 6144} with random bits, compared against the golden model → 2K+6 symbols, exact match; the stream fed into `top` reproduces reference `extrinsic_6144.txt` for K=6144.
- **Backpressure:** `valid_in` random 50% duty → identical symbol sequence to the full-rate run; no symbol emitted without a handshake; a `valid_in` during `ready`=0 consumes nothing.
- **Illegal length:** `blklen`=39 and `blklen`=6145 → one-cycle `err_blklen`, FSM stays IDLE, `ready`=0; a `valid_blklen` strobe during DATA is ignored and K unchanged.
- **Reset mid-block:** `rst` asserted after 100 bits of K=512 → all outputs 0 at once; a subsequent K=40 block is correct from state 000.

Source files
------------

// File: rtl/rsc_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rsc_stream_encoder
// Purpose  : LTE turbo constituent (RSC) encoder with BPSK soft-symbol output.
//            Takes one information bit per handshake. For each bit it emits
//            the systematic symbol and then the parity symbol. It ends every
//            block with the 3-step trellis termination (x,z pairs), so each
//            block produces 2K+6 symbols.
//            Polynomials: feedback g0 = 1+D^2+D^3, feedforward g1 = 1+D+D^3.
// Ports    :
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   blklen       in   [15:0] block length K, sampled on valid_blklen
//   valid_blklen in   strobe that starts a block (honoured only in IDLE)
//   in_bit       in   information bit
//   valid_in     in   in_bit valid; consumed only when ready is high
//   ready        out  encoder accepts in_bit this cycle
//   out          out  [15:0] signed soft symbol (bit 0 -> +AMP, 1 -> -AMP)
//   valid_out    out  out is valid
//   last_out     out  marks the final tail symbol of a block
//   err_blklen   out  one-cycle pulse for an out-of-range blklen strobe
// Revision : 1.0 - initial release
// ============================================================================
module rsc_stream_encoder #(
  parameter int AMP     = 1024,
  parameter int MIN_BLK = 40,
  parameter int MAX_BLK = 6144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] blklen,
  input  logic        valid_blklen,
  input  logic        in_bit,
  input  logic        valid_in,
  output logic        ready,
  output logic [15:0] out,
  output logic        valid_out,
  output logic        last_out,
  output logic        err_blklen
);

  localparam logic [15:0] SYM_POS  = 16'(AMP);
  localparam logic [15:0] SYM_NEG  = 16'(-AMP);
  localparam logic [15:0] BLK_LO   = 16'(MIN_BLK);
  localparam logic [15:0] BLK_HI   = 16'(MAX_BLK);
  localparam logic [2:0]  TAIL_END = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } fsm_t;

  fsm_t        fsm;
  logic [12:0] blk_k;      // latched block length
  logic [12:0] bit_cnt;    // information bits consumed so far
  logic        s1, s2, s3; // trellis state, s1 is the most recent feedback bit
  logic        phase;      // 0: SYS (accepting a bit), 1: PAR (emitting parity)
  logic        par_bit;    // parity bit held for the cycle after its sys symbol
  logic [2:0]  tail_cnt;   // tail symbol index 0..5

  logic blklen_ok;
  logic handshake;
  logic data_a, data_z;
  logic tail_u, tail_z;

  // BPSK mapping in two's complement.
  function automatic logic [15:0] sym(input logic b);
    return b ? SYM_NEG : SYM_POS;
  endfunction

  always_comb begin
    blklen_ok = (blklen >= BLK_LO) && (blklen <= BLK_HI);
    handshake = ready && valid_in;
    data_a    = in_bit ^ s2 ^ s3;
    data_z    = data_a ^ s1 ^ s3;
    // Tail input cancels the feedback so the shifted-in bit is 0; after three
    // steps the register is flushed back to the all-zero state.
    tail_u    = s2 ^ s3;
    tail_z    = s1 ^ s3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      blk_k      <= '0;
      bit_cnt    <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      phase      <= 1'b0;
      par_bit    <= 1'b0;
      tail_cnt   <= '0;
      ready      <= 1'b0;
      out        <= '0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      err_blklen <= 1'b0;
    end else begin
      // Pulse-type outputs default low every cycle.
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      err_blklen <= 1'b0;

      unique case (fsm)
        IDLE: begin
          ready <= 1'b0;
          if (valid_blklen) begin
            if (blklen_ok) begin
              blk_k   <= blklen[12:0];
              bit_cnt <= '0;
              s1      <= 1'b0;
              s2      <= 1'b0;
              s3      <= 1'b0;
              phase   <= 1'b0;
              ready   <= 1'b1;
              fsm     <= DATA;
            end else begin
              err_blklen <= 1'b1;
            end
          end
        end

        DATA: begin
          if (!phase) begin
            // SYS phase: idle (valid_out low) until a bit is handshaken.
            if (handshake) begin
              out        <= sym(in_bit);
              valid_out  <= 1'b1;
              par_bit    <= data_z;
              s1         <= data_a;
              s2         <= s1;
              s3         <= s2;
              bit_cnt    <= bit_cnt + 13'd1;
              phase      <= 1'b1;
              ready      <= 1'b0;
            end
          end else begin
            // PAR phase: parity of the bit taken last cycle.
            out       <= sym(par_bit);
            valid_out <= 1'b1;
            phase     <= 1'b0;
            if (bit_cnt == blk_k) begin
              tail_cnt <= '0;
              fsm      <= TAIL;
            end else begin
              ready <= 1'b1;
            end
          end
        end

        TAIL: begin
          valid_out <= 1'b1;
          ready     <= 1'b0;
          if (!tail_cnt[0]) begin
            // Even index: tail systematic x, advance the trellis.
            out     <= sym(tail_u);
            par_bit <= tail_z;
            s1      <= 1'b0;
            s2      <= s1;
            s3      <= s2;
          end else begin
            out <= sym(par_bit);
          end
          tail_cnt <= tail_cnt + 3'd1;
          if (tail_cnt == TAIL_END) begin
            last_out <= 1'b1;
            fsm      <= IDLE;
          end
        end

        default: begin
          ready <= 1'b0;
          fsm   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
